regfile_write_arbiter: RTL and testbench

//  Producer side of the 64-bit, 32-entry register file write port (BusW/RW/RegWr).

---
 rtl/regfile_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Producer side of the register file write port. Writeback results from
//   the load path (Mem*) and the ALU path (Alu*) are accepted through
//   valid/ready handshakes and placed in an in-order queue. The queue drains
//   at most one entry per cycle into the registered write port
//   (BusW/RW/RegWr). Two combinational forwarding lookups report the newest
//   value that is still pending for a register.
//
// Ports
//   Clk, ResetN                 clock, asynchronous active-low reset
//   MemValid/MemRd/MemData      load result in, MemReady back-pressure out
//   AluValid/AluRd/AluData      ALU result in, AluReady back-pressure out
//   BusW/RW/RegWr               registered register file write port
//   FwdRA -> FwdAHit/FwdAData   forwarding lookup A
//   FwdRB -> FwdBHit/FwdBData   forwarding lookup B
//   Pending                     queue occupancy (0..DEPTH)
//   Idle                        nothing queued and nothing being written
module regfile_write_arbiter #(
    parameter int DEPTH    = 4,
    parameter int DW       = 64,
    parameter int AW       = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                       Clk,
    input  logic                       ResetN,
    input  logic                       MemValid,
    input  logic [AW-1:0]              MemRd,
    input  logic [DW-1:0]              MemData,
    output logic                       MemReady,
    input  logic                       AluValid,
    input  logic [AW-1:0]              AluRd,
    input  logic [DW-1:0]              AluData,
    output logic                       AluReady,
    output logic [DW-1:0]              BusW,
    output logic [AW-1:0]              RW,
    output logic                       RegWr,
    input  logic [AW-1:0]              FwdRA,
    output logic                       FwdAHit,
    output logic [DW-1:0]              FwdAData,
    input  logic [AW-1:0]              FwdRB,
    output logic                       FwdBHit,
    output logic [DW-1:0]              FwdBData,
    output logic [$clog2(DEPTH+1)-1:0] Pending,
    output logic                       Idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] qRd   [DEPTH];
    logic [DW-1:0] qData [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;

    logic [CW-1:0] free;
    logic          memPush;
    logic          aluPush;
    logic          pop;
    logic [PW-1:0] aluSlot;
    logic [CW-1:0] pushCnt;

    // Ready looks only at registered occupancy, so a same-edge pop never
    // makes room. The ALU path needs two free slots so that a simultaneous
    // load result always fits ahead of it.
    assign free     = CW'(DEPTH) - count;
    assign MemReady = (free >= CW'(1));
    assign AluReady = (free >= CW'(2));

    // Zero-register results finish their handshake but never occupy a slot.
    assign memPush = MemValid && MemReady && (MemRd != AW'(ZERO_REG));
    assign aluPush = AluValid && AluReady && (AluRd != AW'(ZERO_REG));
    assign pop     = (count != '0);
    assign aluSlot = memPush ? (wrPtr + PW'(1)) : wrPtr;
    assign pushCnt = CW'(memPush) + CW'(aluPush);

    // Queue storage: contents carry no meaning outside [rdPtr, rdPtr+count)
    always_ff @(posedge Clk) begin
        if (memPush) begin
            qRd[wrPtr]   <= MemRd;
            qData[wrPtr] <= MemData;
        end
        if (aluPush) begin
            qRd[aluSlot]   <= AluRd;
            qData[aluSlot] <= AluData;
        end
    end

    // Queue pointers/occupancy and the registered write port
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            RegWr <= 1'b0;
            RW    <= '0;
            BusW  <= '0;
        end else begin
            wrPtr <= wrPtr + PW'(pushCnt);
            rdPtr <= rdPtr + PW'(pop);
            count <= count + pushCnt - CW'(pop);
            if (pop) begin
                RegWr <= 1'b1;
                RW    <= qRd[rdPtr];
                BusW  <= qData[rdPtr];
            end else begin
                RegWr <= 1'b0;
            end
        end
    end

    assign Pending = count;
    assign Idle    = (count == '0) && !RegWr;

    // Forwarding: scan oldest to youngest so the last match wins. The output
    // stage is older than every queued entry, so it is considered first.
    logic [PW-1:0] slot;

    always_comb begin
        FwdAHit  = 1'b0;
        FwdAData = '0;
        FwdBHit  = 1'b0;
        FwdBData = '0;
        slot     = rdPtr;
        if (RegWr && (RW == FwdRA)) begin
            FwdAHit  = 1'b1;
            FwdAData = BusW;
        end
        if (RegWr && (RW == FwdRB)) begin
            FwdBHit  = 1'b1;
            FwdBData = BusW;
        end
        for (int i = 0; i < DEPTH; i++) begin
            slot = rdPtr + PW'(i);
            if (CW'(i) < count) begin
                if (qRd[slot] == FwdRA) begin
                    FwdAHit  = 1'b1;
                    FwdAData = qData[slot];
                end
                if (qRd[slot] == FwdRB) begin
                    FwdBHit  = 1'b1;
                    FwdBData = qData[slot];
                end
            end
        end
        if (FwdRA == AW'(ZERO_REG)) begin
            FwdAHit  = 1'b0;
            FwdAData = '0;
        end
        if (FwdRB == AW'(ZERO_REG)) begin
            FwdBHit  = 1'b0;
            FwdBData = '0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed and randomized stimulus for regfile_write_arbiter. A reference
//   model holds the pending writes as a plain ordered list plus the last
//   write presented to the register file; every cycle all DUT outputs are
//   compared against it.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 4;
    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int ZR    = 31;

    logic          Clk = 1'b0;
    logic          ResetN = 1'b0;
    logic          MemValid = 1'b0;
    logic [AW-1:0] MemRd = '0;
    logic [DW-1:0] MemData = '0;
    logic          MemReady;
    logic          AluValid = 1'b0;
    logic [AW-1:0] AluRd = '0;
    logic [DW-1:0] AluData = '0;
    logic          AluReady;
    logic [DW-1:0] BusW;
    logic [AW-1:0] RW;
    logic          RegWr;
    logic [AW-1:0] FwdRA = '0;
    logic          FwdAHit;
    logic [DW-1:0] FwdAData;
    logic [AW-1:0] FwdRB = '0;
    logic          FwdBHit;
    logic [DW-1:0] FwdBData;
    logic [2:0]    Pending;
    logic          Idle;

    regfile_write_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .ZERO_REG(ZR)) dut (
        .Clk(Clk), .ResetN(ResetN),
        .MemValid(MemValid), .MemRd(MemRd), .MemData(MemData), .MemReady(MemReady),
        .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData), .AluReady(AluReady),
        .BusW(BusW), .RW(RW), .RegWr(RegWr),
        .FwdRA(FwdRA), .FwdAHit(FwdAHit), .FwdAData(FwdAData),
        .FwdRB(FwdRB), .FwdBHit(FwdBHit), .FwdBData(FwdBData),
        .Pending(Pending), .Idle(Idle)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic          mRegWr = 1'b0;
    logic [AW-1:0] mRW = '0;
    logic [DW-1:0] mBusW = '0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Newest pending value for a register: {hit, data}
    function automatic logic [DW:0] mfwd(input logic [AW-1:0] r);
        logic [DW:0] res;
        res = '0;
        if (r == AW'(ZR)) return res;
        if (mRegWr && mRW == r) res = {1'b1, mBusW};
        foreach (q[i]) if (q[i].rd == r) res = {1'b1, q[i].d};
        return res;
    endfunction

    task automatic modelReset();
        q.delete();
        mRegWr = 1'b0;
        mRW    = '0;
        mBusW  = '0;
    endtask

    // One clock cycle: drive inputs after negedge, check, then model the edge.
    task automatic cycle(input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                         input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic [AW-1:0] fa, input logic [AW-1:0] fb);
        logic        mra, ara;
        logic [DW:0] ea, eb;
        ent_t        e;
        MemValid = mv; MemRd = mrd; MemData = md;
        AluValid = av; AluRd = ard; AluData = ad;
        FwdRA = fa; FwdRB = fb;
        #1;
        mra = (DEPTH - q.size()) >= 1;
        ara = (DEPTH - q.size()) >= 2;
        chk("Pending", 64'(Pending), 64'(q.size()));
        chk("PendingMax", 64'(Pending <= 3'(DEPTH)), 64'(1));
        chk("RegWr", 64'(RegWr), 64'(mRegWr));
        chk("RW", 64'(RW), 64'(mRW));
        chk("BusW", BusW, mBusW);
        chk("Idle", 64'(Idle), 64'(q.size() == 0 && !mRegWr));
        chk("MemReady", 64'(MemReady), 64'(mra));
        chk("AluReady", 64'(AluReady), 64'(ara));
        ea = mfwd(fa);
        eb = mfwd(fb);
        chk("FwdAHit", 64'(FwdAHit), 64'(ea[DW]));
        chk("FwdAData", FwdAData, ea[DW-1:0]);
        chk("FwdBHit", 64'(FwdBHit), 64'(eb[DW]));
        chk("FwdBData", FwdBData, eb[DW-1:0]);
        @(posedge Clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            mRegWr = 1'b1; mRW = e.rd; mBusW = e.d;
        end else begin
            mRegWr = 1'b0;
        end
        if (mv && mra && mrd != AW'(ZR)) begin e.rd = mrd; e.d = md; q.push_back(e); end
        if (av && ara && ard != AW'(ZR)) begin e.rd = ard; e.d = ad; q.push_back(e); end
        @(negedge Clk);
    endtask

    task automatic idle(input int n, input logic [AW-1:0] fa);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, fa, 0);
    endtask

    initial begin
        logic [AW-1:0] r1, r2, fa, fb;
        // Power-on reset
        modelReset();
        repeat (2) @(negedge Clk);
        #1;
        chk("rst_RegWr", 64'(RegWr), 64'(0));
        chk("rst_Pending", 64'(Pending), 64'(0));
        ResetN = 1'b1;
        @(negedge Clk);

        // Single ALU write, then the port goes idle
        cycle(0, 0, 0, 1, 5'd3, 64'hAA, 5'd3, 5'd0);
        cycle(0, 0, 0, 0, 0, 0, 5'd3, 5'd0);
        chk("t1_RW", 64'(RW), 64'(3));
        chk("t1_BusW", BusW, 64'hAA);
        idle(2, 5'd3);
        chk("t1_Idle", 64'(Idle), 64'(1));

        // Same-cycle Mem and ALU to the same register
        cycle(1, 5'd5, 64'd1, 1, 5'd5, 64'd2, 5'd5, 5'd5);
        idle(4, 5'd5);

        // Zero-register write is dropped
        cycle(0, 0, 0, 1, 5'(ZR), 64'hFF, 5'(ZR), 5'(ZR));
        idle(2, 5'(ZR));

        // Back-to-back traffic on both paths
        for (int i = 0; i < 8; i++)
            cycle(1, 5'(2*i), 64'(100+i), 1, 5'(2*i+1), 64'(200+i), 5'(2*i), 5'(2*i+1));
        idle(6, 5'd1);

        // Asynchronous reset with three entries pending
        cycle(1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 5'd1, 5'd2);
        cycle(1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 5'd3, 5'd4);
        chk("t5_Pending3", 64'(Pending), 64'(3));
        MemValid = 0; AluValid = 0;
        #2 ResetN = 1'b0;
        #1;
        chk("t5_RegWr", 64'(RegWr), 64'(0));
        chk("t5_Pending", 64'(Pending), 64'(0));
        modelReset();
        @(posedge Clk);
        @(negedge Clk);
        ResetN = 1'b1;
        idle(4, 5'd1);

        // Randomized traffic
        for (int i = 0; i < 120; i++) begin
            r1 = ($urandom_range(0, 9) == 0) ? 5'(ZR) : 5'($urandom_range(0, 7));
            r2 = ($urandom_range(0, 9) == 0) ? 5'(ZR) : 5'($urandom_range(0, 7));
            fa = ($urandom_range(0, 9) == 0) ? 5'(ZR) : 5'($urandom_range(0, 7));
            fb = 5'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 1)), r1, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), r2, {$urandom, $urandom}, fa, fb);
        end
        idle(6, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
